// File: rtl/dbus_lane_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbus_lane_arbiter_pkg
// Description : Shared data-bus request/response types and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dbus_lane_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_L1_ADDR = 3'd1,
        ST_L1_DATA = 3'd2,
        ST_L2_ADDR = 3'd3,
        ST_L2_DATA = 3'd4,
        ST_HOLD    = 3'd5
    } arb_state_t;

    // True while a bus transaction is pending (request phase or data phase).
    function automatic logic bus_wait_state(input arb_state_t s);
        return (s == ST_L1_ADDR) || (s == ST_L1_DATA) ||
               (s == ST_L2_ADDR) || (s == ST_L2_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_lane_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : dbus_lane_arbiter_watchdog
// Description : Debug watchdog; single pulse after TIMEOUT_CYCLES waiting cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_lane_arbiter_watchdog #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_waiting,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    // With TIMEOUT_CYCLES = 0 the limit equals the reset value, so nothing counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_waiting && (r_cnt != C_LIMIT)) begin
                r_cnt   <= r_cnt + C_ONE;
                r_pulse <= (r_cnt == C_LIMIT - C_ONE);
            end
        end
    end

    assign o_timeout = r_pulse;

endmodule
`default_nettype wire

// File: rtl/dbus_lane_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dbus_lane_arbiter
// Description : Serialises two memory-lane requests onto one dbus in program order.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_lane_arbiter
    import dbus_lane_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  req_1,
    input  dbus_req_t  req_2,
    input  logic       kill_2,
    input  logic       flush,
    input  logic       advance,
    output dbus_resp_t resp_1,
    output dbus_resp_t resp_2,
    output logic       done_1,
    output logic       done_2,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp,
    output logic       bus_timeout
);

    arb_state_t r_state;
    arb_state_t w_next;
    arb_state_t w_after_l1;
    logic       r_flushed;
    logic       w_keep;
    logic       w_lat_1;
    logic       w_lat_2;
    logic       w_flush_set;
    dbus_resp_t r_resp_1;
    dbus_resp_t r_resp_2;
    dbus_resp_t w_fill;

    // A flush seen at or after addr_ok lets the transaction finish but discards its data.
    assign w_keep = !(flush || r_flushed);
    assign w_fill = '{addr_ok: 1'b1, data_ok: 1'b1, data: dresp.data};

    always_comb begin
        w_next      = r_state;
        w_after_l1  = (req_2.valid && !kill_2 && w_keep) ? ST_L2_ADDR : ST_HOLD;
        w_lat_1     = 1'b0;
        w_lat_2     = 1'b0;
        w_flush_set = 1'b0;
        dreq        = '0;
        done_1      = 1'b0;
        done_2      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush)                      w_next = ST_HOLD;
                else if (req_1.valid)           w_next = ST_L1_ADDR;
                else if (req_2.valid && !kill_2) w_next = ST_L2_ADDR;
                else                            w_next = ST_HOLD;
            end
            ST_L1_ADDR: begin
                dreq   = req_1;
                done_2 = !req_2.valid;
                if (dresp.addr_ok) begin
                    if (dresp.data_ok) begin
                        w_lat_1 = w_keep;
                        w_next  = w_after_l1;
                    end else begin
                        w_flush_set = flush;
                        w_next      = ST_L1_DATA;
                    end
                end else if (flush) begin
                    w_next = ST_HOLD;
                end
            end
            ST_L1_DATA: begin
                done_2 = !req_2.valid;
                if (dresp.data_ok) begin
                    w_lat_1 = w_keep;
                    w_next  = w_after_l1;
                end else begin
                    w_flush_set = flush;
                end
            end
            ST_L2_ADDR: begin
                dreq   = req_2;
                done_1 = 1'b1;
                if (dresp.addr_ok) begin
                    if (dresp.data_ok) begin
                        w_lat_2 = w_keep;
                        w_next  = ST_HOLD;
                    end else begin
                        w_flush_set = flush;
                        w_next      = ST_L2_DATA;
                    end
                end else if (flush || kill_2) begin
                    w_next = ST_HOLD;
                end
            end
            ST_L2_DATA: begin
                done_1 = 1'b1;
                if (dresp.data_ok) begin
                    w_lat_2 = w_keep;
                    w_next  = ST_HOLD;
                end else begin
                    w_flush_set = flush;
                end
            end
            ST_HOLD: begin
                done_1 = 1'b1;
                done_2 = 1'b1;
                if (advance) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_flushed <= 1'b0;
            r_resp_1  <= '0;
            r_resp_2  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_HOLD)  r_flushed <= 1'b0;
            else if (w_flush_set)    r_flushed <= 1'b1;
            if (r_state == ST_HOLD && advance) begin
                r_resp_1 <= '0;
                r_resp_2 <= '0;
            end
            if (w_lat_1) r_resp_1 <= w_fill;
            if (w_lat_2) r_resp_2 <= w_fill;
        end
    end

    assign resp_1 = r_resp_1;
    assign resp_2 = r_resp_2;

    dbus_lane_arbiter_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_next != r_state),
        .i_waiting (bus_wait_state(r_state)),
        .o_timeout (bus_timeout)
    );

    a_advance_in_hold: assert property (@(posedge clk) disable iff (reset)
        advance |-> (r_state == ST_HOLD));

endmodule
`default_nettype wire

// File: tb/tb_dbus_lane_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_lane_arbiter
// Description : Directed self-checking bench for dbus_lane_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_lane_arbiter;
    import dbus_lane_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  req_1;
    dbus_req_t  req_2;
    logic       kill_2;
    logic       flush;
    logic       advance;
    dbus_resp_t resp_1;
    dbus_resp_t resp_2;
    logic       done_1;
    logic       done_2;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       bus_timeout;

    int checks = 0;
    int errors = 0;

    dbus_lane_arbiter #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_1       (req_1),
        .req_2       (req_2),
        .kill_2      (kill_2),
        .flush       (flush),
        .advance     (advance),
        .resp_1      (resp_1),
        .resp_2      (resp_2),
        .done_1      (done_1),
        .done_2      (done_2),
        .dreq        (dreq),
        .dresp       (dresp),
        .bus_timeout (bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic a_ok, input logic d_ok, input logic [31:0] d);
        dresp = '{addr_ok: a_ok, data_ok: d_ok, data: d};
    endtask

    task automatic next_pair();
        advance = 1'b1;
        cyc();
        advance = 1'b0;
    endtask

    function automatic dbus_req_t mk_req(input logic v, input logic [31:0] a,
                                         input logic [3:0] s, input logic [31:0] d);
        return '{valid: v, addr: a, size: 3'd2, strobe: s, data: d};
    endfunction

    initial begin
        reset   = 1'b1;
        req_1   = '0;
        req_2   = '0;
        kill_2  = 1'b0;
        flush   = 1'b0;
        advance = 1'b0;
        dresp   = '0;
        #2;
        check("rst_dreq",    80'(dreq),        80'(0));
        check("rst_resp_1",  80'(resp_1),      80'(0));
        check("rst_resp_2",  80'(resp_2),      80'(0));
        check("rst_done_1",  80'(done_1),      80'(0));
        check("rst_done_2",  80'(done_2),      80'(0));
        check("rst_timeout", 80'(bus_timeout), 80'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Both loads, zero-wait bus; this cycle is IDLE.
        req_1 = mk_req(1'b1, 32'h0000_0100, 4'h0, 32'h0);
        req_2 = mk_req(1'b1, 32'h0000_0200, 4'h0, 32'h0);
        #1;
        check("t1_idle_dreq_v", 80'(dreq.valid), 80'(0));
        cyc(); bus(1'b1, 1'b1, 32'hAAAA_0001); #1;
        check("t1_dreq_l1", 80'(dreq), 80'(req_1));
        cyc(); bus(1'b1, 1'b1, 32'hBBBB_0002); #1;
        check("t1_dreq_l2",     80'(dreq),          80'(req_2));
        check("t1_done_1",      80'(done_1),        80'(1));
        check("t1_done_2_low",  80'(done_2),        80'(0));
        check("t1_resp_1_data", 80'(resp_1.data),   80'(32'hAAAA_0001));
        check("t1_resp_1_ok",   80'(resp_1.data_ok), 80'(1));
        cyc(); bus(1'b0, 1'b0, 32'h0); #1;
        check("t1_done_2",      80'(done_2),        80'(1));
        check("t1_resp_2_data", 80'(resp_2.data),   80'(32'hBBBB_0002));
        check("t1_hold_dreq_v", 80'(dreq.valid),    80'(0));
        check("t1_timeout",     80'(bus_timeout),   80'(0));
        next_pair();
        check("t1_resp_1_clr",  80'(resp_1.data_ok), 80'(0));

        // Lane 1 store with slow bus, lane 2 load.
        req_1 = mk_req(1'b1, 32'h0000_0300, 4'hF, 32'h1234_5678);
        req_2 = mk_req(1'b1, 32'h0000_0400, 4'h0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            cyc(); bus(1'b0, 1'b0, 32'h0); #1;
            check($sformatf("t2_dreq_wait%0d", i), 80'(dreq), 80'(req_1));
        end
        cyc(); bus(1'b1, 1'b0, 32'h0); #1;
        check("t2_dreq_aok", 80'(dreq), 80'(req_1));
        cyc(); bus(1'b0, 1'b0, 32'h0); #1;
        check("t2_data1_dreq_v", 80'(dreq.valid), 80'(0));
        check("t2_data1_done_1", 80'(done_1),     80'(0));
        cyc(); bus(1'b0, 1'b1, 32'h0); #1;
        check("t2_data2_dreq_v", 80'(dreq.valid), 80'(0));
        cyc(); bus(1'b1, 1'b1, 32'hCCCC_0003); #1;
        check("t2_dreq_l2",   80'(dreq),           80'(req_2));
        check("t2_resp_1_ok", 80'(resp_1.data_ok), 80'(1));
        cyc(); bus(1'b0, 1'b0, 32'h0); #1;
        check("t2_done_2",      80'(done_2),      80'(1));
        check("t2_resp_2_data", 80'(resp_2.data), 80'(32'hCCCC_0003));
        check("t2_timeout",     80'(bus_timeout), 80'(0));
        next_pair();

        // kill_2 at lane-1 completion.
        req_1 = mk_req(1'b1, 32'h0000_0500, 4'h0, 32'h0);
        req_2 = mk_req(1'b1, 32'h0000_0600, 4'h0, 32'h0);
        cyc(); bus(1'b1, 1'b1, 32'hEEEE_0005); kill_2 = 1'b1; #1;
        check("t3_dreq_l1", 80'(dreq), 80'(req_1));
        cyc(); bus(1'b0, 1'b0, 32'h0); #1;
        check("t3_dreq_v",      80'(dreq.valid),     80'(0));
        check("t3_done_2",      80'(done_2),         80'(1));
        check("t3_resp_2_ok",   80'(resp_2.data_ok), 80'(0));
        check("t3_resp_1_data", 80'(resp_1.data),    80'(32'hEEEE_0005));
        next_pair();
        kill_2 = 1'b0;

        // Flush while lane 1 waits for data.
        req_1 = mk_req(1'b1, 32'h0000_0700, 4'h0, 32'h0);
        req_2 = mk_req(1'b1, 32'h0000_0800, 4'h0, 32'h0);
        cyc(); bus(1'b1, 1'b0, 32'h0); #1;
        cyc(); bus(1'b0, 1'b0, 32'h0); flush = 1'b1; #1;
        check("t4_flush_done_1", 80'(done_1), 80'(0));
        cyc(); bus(1'b0, 1'b1, 32'hFFFF_0006); flush = 1'b0; #1;
        check("t4_wait_done_1", 80'(done_1),     80'(0));
        check("t4_wait_dreq_v", 80'(dreq.valid), 80'(0));
        cyc(); bus(1'b0, 1'b0, 32'h0); #1;
        check("t4_hold_done_1", 80'(done_1),         80'(1));
        check("t4_hold_done_2", 80'(done_2),         80'(1));
        check("t4_resp_1_ok",   80'(resp_1.data_ok), 80'(0));
        cyc(); #1;
        check("t4_no_l2_dreq_v", 80'(dreq.valid), 80'(0));
        next_pair();

        // Only lane 2 valid.
        req_1 = mk_req(1'b0, 32'h0, 4'h0, 32'h0);
        req_2 = mk_req(1'b1, 32'h0000_0900, 4'h0, 32'h0);
        cyc(); bus(1'b1, 1'b1, 32'h1111_0007); #1;
        check("t5_dreq_l2",   80'(dreq),   80'(req_2));
        check("t5_l2_done_1", 80'(done_1), 80'(1));
        check("t5_l2_done_2", 80'(done_2), 80'(0));
        cyc(); bus(1'b0, 1'b0, 32'h0); #1;
        check("t5_done_1",      80'(done_1),         80'(1));
        check("t5_done_2",      80'(done_2),         80'(1));
        check("t5_resp_2_data", 80'(resp_2.data),    80'(32'h1111_0007));
        check("t5_resp_1_ok",   80'(resp_1.data_ok), 80'(0));
        next_pair();

        // No requests: HOLD on the next cycle.
        req_2 = '0;
        cyc(); #1;
        check("t5b_done_1", 80'(done_1),     80'(1));
        check("t5b_done_2", 80'(done_2),     80'(1));
        check("t5b_dreq_v", 80'(dreq.valid), 80'(0));
        next_pair();

        // addr_ok withheld: one watchdog pulse in the fifth waiting cycle.
        req_1 = mk_req(1'b1, 32'h0000_0A00, 4'h0, 32'h0);
        req_2 = mk_req(1'b1, 32'h0000_0B00, 4'h0, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            cyc(); bus(1'b0, 1'b0, 32'h0); #1;
            check($sformatf("t6_timeout_c%0d", i), 80'(bus_timeout), 80'(i == 5));
        end
        check("t6_dreq_held", 80'(dreq), 80'(req_1));
        cyc(); bus(1'b1, 1'b1, 32'h2222_0008); #1;
        cyc(); bus(1'b1, 1'b0, 32'h0); #1;
        check("t6_dreq_l2", 80'(dreq), 80'(req_2));
        cyc(); bus(1'b0, 1'b0, 32'h0); #1;
        check("t6_pre_done_1", 80'(done_1),      80'(1));
        check("t6_pre_resp_1", 80'(resp_1.data), 80'(32'h2222_0008));
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_resp_1",  80'(resp_1),      80'(0));
        check("t6_rst_resp_2",  80'(resp_2),      80'(0));
        check("t6_rst_done_1",  80'(done_1),      80'(0));
        check("t6_rst_done_2",  80'(done_2),      80'(0));
        check("t6_rst_dreq",    80'(dreq),        80'(0));
        check("t6_rst_timeout", 80'(bus_timeout), 80'(0));
        cyc();
        reset = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
`default_nettype wire
